// File: rtl/mdu_div_seq_if.sv
// Divider request/response bundle between the execute stage and mdu_div_seq.
// Carries the operands, the start/abort controls, and the registered results.
// Optional abort signal is present only when MDU_DIV_ABORT_EN is defined.
interface mdu_div_seq_if #(
    parameter int WIDTH = 32
);
    logic             start;
`ifdef MDU_DIV_ABORT_EN
    logic             abort;
`endif
    logic             is_signed;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             div_zero;

    // Pipeline side: issues divides, consumes results.
    modport master (
        output start,
`ifdef MDU_DIV_ABORT_EN
        output abort,
`endif
        output is_signed,
        output dividend,
        output divisor,
        input  busy,
        input  done,
        input  quotient,
        input  remainder,
        input  div_zero
    );

    // Divider side.
    modport slave (
        input  start,
`ifdef MDU_DIV_ABORT_EN
        input  abort,
`endif
        input  is_signed,
        input  dividend,
        input  divisor,
        output busy,
        output done,
        output quotient,
        output remainder,
        output div_zero
    );
endinterface

// File: rtl/mdu_div_seq.sv
// Radix-2 restoring DIV/DIVU, one quotient bit per clock; quotient -> LO, remainder -> HI.
// Latency: done pulses WIDTH clocks after the accepting edge; back-to-back start accepted in DONE.
// Backpressure: busy stalls the pipeline; start during CALC is ignored. Optional MDU_DIV_ABORT_EN adds abort.
module mdu_div_seq #(
    parameter int               WIDTH  = 32,
    parameter logic [WIDTH-1:0] ZERO_Q = {WIDTH{1'b1}}
) (
    input  logic          clk,
    input  logic          rst,
    mdu_div_seq_if.slave  bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [CW-1:0]    cnt_q;
    logic [WIDTH-1:0] rem_q;        // partial remainder
    logic [WIDTH-1:0] quo_q;        // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] dvs_q;        // divisor magnitude
    logic [WIDTH-1:0] dvd_raw_q;    // original dividend, returned on divide-by-zero
    logic             sgn_q;
    logic             neg_dvd_q;
    logic             neg_dvs_q;
    logic             dvs_zero_q;
    logic             busy_q;
    logic             done_q;
    logic [WIDTH-1:0] quotient_q;
    logic [WIDTH-1:0] remainder_q;
    logic             div_zero_q;

    logic [WIDTH:0]   rem_ext;
    logic [WIDTH:0]   diff;
    logic [WIDTH-1:0] rem_d;
    logic [WIDTH-1:0] quo_d;
    logic [WIDTH-1:0] q_fin;
    logic [WIDTH-1:0] r_fin;
    logic [WIDTH-1:0] dvd_mag;
    logic [WIDTH-1:0] dvs_mag;
    logic             abort_w;

`ifdef MDU_DIV_ABORT_EN
    assign abort_w = bus.abort;
`else
    assign abort_w = 1'b0;
`endif

    // One restoring step plus sign fix-up of the step's result and operand magnitudes at accept.
    always_comb begin
        rem_ext = {rem_q, quo_q[WIDTH-1]};
        diff    = rem_ext - {1'b0, dvs_q};
        quo_d   = {quo_q[WIDTH-2:0], ~diff[WIDTH]};
        rem_d   = diff[WIDTH] ? rem_ext[WIDTH-1:0] : diff[WIDTH-1:0];

        q_fin = (sgn_q && (neg_dvd_q ^ neg_dvs_q)) ? -quo_d : quo_d;
        r_fin = (sgn_q && neg_dvd_q) ? -rem_d : rem_d;
        if (dvs_zero_q) begin
            q_fin = ZERO_Q;
            r_fin = dvd_raw_q;
        end

        // |0x8000_0000| stays 0x8000_0000, which is correct as an unsigned magnitude.
        dvd_mag = (bus.is_signed && bus.dividend[WIDTH-1]) ? -bus.dividend : bus.dividend;
        dvs_mag = (bus.is_signed && bus.divisor[WIDTH-1])  ? -bus.divisor  : bus.divisor;
    end

    // Control FSM, datapath registers and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            dvs_q       <= '0;
            dvd_raw_q   <= '0;
            sgn_q       <= 1'b0;
            neg_dvd_q   <= 1'b0;
            neg_dvs_q   <= 1'b0;
            dvs_zero_q  <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            quotient_q  <= '0;
            remainder_q <= '0;
            div_zero_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                CALC: begin
                    if (abort_w) begin
                        // Flush: drop the operation, keep the previous results.
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        rem_q <= rem_d;
                        quo_q <= quo_d;
                        cnt_q <= cnt_q + CW'(1);
                        if (cnt_q == LAST_CNT) begin
                            state_q     <= DONE;
                            busy_q      <= 1'b0;
                            done_q      <= 1'b1;
                            quotient_q  <= q_fin;
                            remainder_q <= r_fin;
                            div_zero_q  <= dvs_zero_q;
                        end
                    end
                end
                default: begin
                    // IDLE and DONE both accept a new request.
                    if (bus.start) begin
                        state_q    <= CALC;
                        busy_q     <= 1'b1;
                        cnt_q      <= '0;
                        rem_q      <= '0;
                        quo_q      <= dvd_mag;
                        dvs_q      <= dvs_mag;
                        dvd_raw_q  <= bus.dividend;
                        sgn_q      <= bus.is_signed;
                        neg_dvd_q  <= bus.dividend[WIDTH-1];
                        neg_dvs_q  <= bus.divisor[WIDTH-1];
                        dvs_zero_q <= (bus.divisor == '0);
                    end else begin
                        state_q <= IDLE;
                    end
                end
            endcase
        end
    end

    assign bus.busy      = busy_q;
    assign bus.done      = done_q;
    assign bus.quotient  = quotient_q;
    assign bus.remainder = remainder_q;
    assign bus.div_zero  = div_zero_q;
endmodule

// File: doc/mdu_div_seq.md
Name: mdu_div_seq

Overview:
Multi-cycle 32-bit integer divider for DIV/DIVU in the execute stage; writes directly into the HI/LO register pair.
- Uses a radix-2 restoring algorithm, one quotient bit per clock.
- On completion it drives quotient (to LO) and remainder (to HI), plus a one-cycle write strobe that connects straight to both registers' write inputs.
- Pipeline control stalls on busy.

Parameters:
WIDTH, 32, operand/result width in bits; counter width is clog2(WIDTH)+1.
ZERO_Q, 32'hFFFF_FFFF, quotient produced on divide-by-zero.

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  reset, asynchronous, active-low (0 = reset)
start  input  1  request a divide; sampled on rising edge
is_signed  input  1  1 = DIV (two's complement), 0 = DIVU; sampled with start
dividend  input  WIDTH  numerator (rs); sampled with start
divisor  input  WIDTH  denominator (rt); sampled with start
busy  output  1  divide in progress; stall request to pipeline
done  output  1  one-cycle pulse; results valid; drives HI/LO write
quotient  output  WIDTH  registered quotient, to LO
remainder  output  WIDTH  registered remainder, to HI
div_zero  output  1  registered; set with done when divisor was 0

Behaviour:
- Reset (rst=0, async): state IDLE; busy=0, done=0, quotient=0, remainder=0, div_zero=0; counter and working registers cleared. Takes effect mid-operation with no completion and no done pulse.
- States: IDLE, CALC, DONE.
- IDLE/DONE + start=1 at edge E0:
  - latch is_signed and sign bits of both operands;
  - load magnitudes (|x| when is_signed, else raw);
  - clear partial remainder; counter=0; go to CALC.
- start in DONE is accepted, giving back-to-back operation.
- CALC, each edge:
  - shift {rem,quo} left 1;
  - trial subtract rem - |divisor| (WIDTH+1 bits);
  - if non-negative, keep the difference and set the quotient LSB;
  - counter+1.
- On the edge where counter reaches WIDTH (E32), go to DONE and register the final results:
  - quotient negated if the signs differ (signed only);
  - remainder negated if the dividend is negative (signed only), so the remainder sign follows the dividend.
- Latency: done=1 in the cycle following E32, i.e. 32 clocks after the accepting edge. busy=1 in every CALC cycle, 0 in IDLE and DONE.
- DONE lasts exactly one cycle, then IDLE (or CALC if start=1).
- quotient, remainder and div_zero hold their values until the next DONE or reset.
- start while in CALC: ignored, with no effect on the operation or the latched operands. Input changes during CALC are ignored.
- Divisor 0: runs the full latency; quotient=ZERO_Q, remainder=original dividend (unsigned view), div_zero=1. Otherwise div_zero=0 at DONE.
- Signed overflow 0x8000_0000 / 0xFFFF_FFFF: quotient=0x8000_0000, remainder=0, no flag.
- Arithmetic: magnitude of 0x8000_0000 is 0x8000_0000 (unsigned); negation is two's complement modulo 2^WIDTH.

Optional Feature:
- Macro MDU_DIV_ABORT_EN.
- Defined:
  - adds input port abort (1 bit, after start);
  - abort=1 at any edge in CALC returns to IDLE next cycle, with no done pulse and quotient/remainder/div_zero unchanged;
  - abort in IDLE/DONE has no effect;
  - abort and start at the same edge: abort wins only in CALC;
  - used for exception flush.
- Undefined: no abort port; every accepted operation runs to DONE.

Test Plan:
- DIVU 100/7: start at E0 -> busy=1 for 32 cycles, done pulse at cycle 33, quotient=14, remainder=2, div_zero=0.
- DIV -7/2 (0xFFFF_FFF9 / 2) -> quotient=0xFFFF_FFFD, remainder=0xFFFF_FFFF; DIV 7/-2 -> quotient=0xFFFF_FFFD, remainder=1.
- DIV 0x8000_0000 / 0xFFFF_FFFF -> quotient=0x8000_0000, remainder=0; DIVU 0xFFFF_FFFF/1 -> quotient=0xFFFF_FFFF, remainder=0.
- DIVU 0x1234/0 -> after 32 cycles quotient=0xFFFF_FFFF, remainder=0x1234, div_zero=1; next DIVU 9/3 -> div_zero=0, quotient=3.
- start pulsed with 5/1 at cycle 10 of a running 100/7 -> ignored, result 14/2. Then start asserted during the DONE cycle -> second op accepted with no idle gap.
- rst=0 asynchronously at cycle 15 of an op -> all outputs 0 immediately, no done. With MDU_DIV_ABORT_EN: abort at cycle 20 -> IDLE, no done, previous results retained.
